// File: rtl/stream_pkg.sv
// Shared stream helpers: lane index width, one-hot counting and beat control fields.
// Used by stream_downsize and stream_upsize.
package stream_pkg;

   // Index width for a lane count, never narrower than one bit.
   function automatic int unsigned lane_idx_w(input int unsigned ratio);
      return (ratio > 2) ? $clog2(ratio) : 1;
   endfunction

   function automatic int unsigned count_ones(input logic [31:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 32; i++) begin
         n += 32'(v[i]);
      end
      return n;
   endfunction

   typedef struct packed {
      logic last;
      logic valid;
   } beat_ctrl_t;

endpackage

// File: rtl/stream_lane_pick.sv
// Lowest-set-bit priority encoder over a lane mask, with any-set and exactly-one flags.
module stream_lane_pick
   import stream_pkg::*;
#(
   parameter int unsigned Lanes = 2,
   parameter int unsigned IdxW  = lane_idx_w(Lanes)
) (
   input  logic [Lanes-1:0] mask_i,
   output logic [IdxW-1:0]  idx_o,
   output logic             any_o,
   output logic             one_o
);

   always_comb begin
      idx_o = '0;
      for (int i = int'(Lanes) - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            idx_o = IdxW'(i);
         end
      end
      any_o = |mask_i;
      one_o = (count_ones(32'(mask_i)) == 1);
   end

endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: emits one narrow beat per kept lane, ascending lane order.
// STREAM_DOWNSIZE_SKID_EN adds an input skid register and a registered s_ready_o.
module stream_downsize
   import stream_pkg::*;
#(
   parameter int unsigned T_DATA_WIDTH = 4,
   parameter int unsigned T_DATA_RATIO = 2
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] s_data_i,
   input  logic [T_DATA_RATIO-1:0]                   s_keep_i,
   input  logic                                      s_last_i,
   input  logic                                      s_valid_i,
   output logic                                      s_ready_o,
   output logic [T_DATA_WIDTH-1:0]                   m_data_o,
   output logic                                      m_last_o,
   output logic                                      m_valid_o,
   input  logic                                      m_ready_i
);

   localparam int unsigned IdxW = lane_idx_w(T_DATA_RATIO);

   typedef logic [T_DATA_RATIO-1:0][T_DATA_WIDTH-1:0] lanes_t;

   lanes_t                  hold_data_q, hold_data_d;
   logic [T_DATA_RATIO-1:0] rem_mask_q, rem_mask_d;
   beat_ctrl_t              hold_q, hold_d;

   logic [IdxW-1:0]         cur_lane;
   logic                    rem_any, rem_one;
   logic                    out_hs, hold_free, load;

   lanes_t                  src_data;
   logic [T_DATA_RATIO-1:0] src_keep;
   logic                    src_last, src_valid;

   stream_lane_pick #(
      .Lanes (T_DATA_RATIO),
      .IdxW  (IdxW)
   ) u_lane_pick (
      .mask_i (rem_mask_q),
      .idx_o  (cur_lane),
      .any_o  (rem_any),
      .one_o  (rem_one)
   );

   assign m_valid_o = hold_q.valid;
   assign m_data_o  = hold_data_q[cur_lane];
   assign m_last_o  = hold_q.valid & hold_q.last & rem_one;

   assign out_hs    = hold_q.valid & rem_any & m_ready_i;
   // Holding stage can take a new beat when empty or when its final lane leaves now.
   assign hold_free = ~hold_q.valid | (out_hs & rem_one);
   assign load      = src_valid & hold_free & (|src_keep);

`ifdef STREAM_DOWNSIZE_SKID_EN
   lanes_t                  skid_data_q, skid_data_d;
   logic [T_DATA_RATIO-1:0] skid_keep_q, skid_keep_d;
   logic                    skid_last_q, skid_last_d;
   logic                    skid_valid_q, skid_valid_d;
   logic                    in_hs;

   assign s_ready_o = ~skid_valid_q;
   assign in_hs     = s_valid_i & s_ready_o;
   assign src_valid = skid_valid_q | in_hs;
   assign src_data  = skid_valid_q ? skid_data_q : s_data_i;
   assign src_keep  = skid_valid_q ? skid_keep_q : s_keep_i;
   assign src_last  = skid_valid_q ? skid_last_q : s_last_i;

   always_comb begin
      skid_data_d  = skid_data_q;
      skid_keep_d  = skid_keep_q;
      skid_last_d  = skid_last_q;
      skid_valid_d = skid_valid_q;
      if (skid_valid_q && hold_free) begin
         skid_valid_d = 1'b0;
      end
      // Zero-keep beats carry nothing, so they are dropped rather than parked.
      if (in_hs && !hold_free && (|s_keep_i)) begin
         skid_data_d  = s_data_i;
         skid_keep_d  = s_keep_i;
         skid_last_d  = s_last_i;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         skid_data_q  <= '0;
         skid_keep_q  <= '0;
         skid_last_q  <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         skid_data_q  <= skid_data_d;
         skid_keep_q  <= skid_keep_d;
         skid_last_q  <= skid_last_d;
         skid_valid_q <= skid_valid_d;
      end
   end
`else
   assign s_ready_o = hold_free;
   assign src_valid = s_valid_i;
   assign src_data  = s_data_i;
   assign src_keep  = s_keep_i;
   assign src_last  = s_last_i;
`endif

   always_comb begin
      hold_data_d = hold_data_q;
      rem_mask_d  = rem_mask_q;
      hold_d      = hold_q;
      if (out_hs) begin
         rem_mask_d[cur_lane] = 1'b0;
         if (rem_one) begin
            hold_d.valid = 1'b0;
         end
      end
      if (load) begin
         hold_data_d  = src_data;
         rem_mask_d   = src_keep;
         hold_d.last  = src_last;
         hold_d.valid = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_data_q <= '0;
         rem_mask_q  <= '0;
         hold_q      <= '0;
      end else begin
         hold_data_q <= hold_data_d;
         rem_mask_q  <= rem_mask_d;
         hold_q      <= hold_d;
      end
   end

endmodule
